dm_param: RTL and testbench
===========================

// Module: dm_param
// PURPOSE
// Parametrised single-ported data memory for the CPU data path. Adds configurable
// width/depth, byte-lane write enables, selectable read latency, and a post-reset
// hardware clear sequence with a busy flag. Reads and writes occur on posedge clk.
// Illegal simultaneous re/we is flagged; no memory access occurs.
// PARAMETERS
// DATA_W      16  word width in bits; multiple of 8
// ADDR_W      13  address width; depth = 2**ADDR_W words (default 8K x 16)
// RD_LAT      1   read latency in cycles, 1 or 2 (2 adds an output register stage)
// CLR_ON_RST  1   1: zero every location after reset; 0: skip clear, contents undefined
// PORTS
// clk       in   1          clock; all state updates on posedge
// rst_n     in   1          asynchronous active-low reset
// addr      in   ADDR_W     word address of request
// re        in   1          read request
// we        in   1          write request
// be        in   DATA_W/8   byte-lane enables for writes; be[i] covers bits 8i+7:8i
// wrt_data  in   DATA_W     write data
// rd_data   out  DATA_W     read data; holds last value until next read completes
// rd_vld    out  1          one-cycle pulse when rd_data is updated
// busy      out  1          high during clear; requests are ignored while high
// err       out  1          one-cycle pulse: re&we seen in the same cycle while not busy
// BEHAVIOUR
// - Reset (rst_n=0, async): rd_data=0, rd_vld=0, err=0, pipeline valids=0, clr_addr=0.
//   busy=CLR_ON_RST. FSM enters CLEAR if CLR_ON_RST=1, otherwise IDLE. Memory array is
//   not reset.
// - FSM states: CLEAR, IDLE.
//   - CLEAR: each cycle writes 0 to mem[clr_addr], then clr_addr++.
//   - After the write to 2**ADDR_W-1: go to IDLE and drop busy on the next edge.
//   - Clear takes exactly 2**ADDR_W cycles after rst_n rises.
//   - While in CLEAR, re/we/be are ignored, with no rd_vld and no err.
// - Reset asserted mid-CLEAR: async abort. On release, clear restarts from address 0.
// - IDLE accept rules, sampled at posedge:
//   - re=1, we=0: read accepted.
//   - we=1, re=0: write accepted.
//   - re=1, we=1: no access; err=1 next cycle; rd_data is unchanged.
//   - re=0, we=0: nothing happens.
// - Write: for each i with be[i]=1, mem[addr][8i+7:8i] <= wrt_data[8i+7:8i].
//   Other lanes keep their values. be=0 makes the write a no-op without error.
// - Read with RD_LAT=1: on the accept edge, rd_data <= mem[addr] and rd_vld=1 for
//   the following cycle.
// - Read with RD_LAT=2: the array output registers internally, then rd_data/rd_vld
//   update one edge later.
// - Back-to-back reads are accepted every cycle: rd_vld stays high continuously and
//   data returns in request order.
// - A read issued the cycle after a write to the same address returns the new data.
//   Single port, so no same-cycle collision is possible.
// - addr is exactly ADDR_W bits, so every address is in range and no wrap logic is
//   needed. clr_addr wraps to 0 only on exit from CLEAR.
// TESTING
// - Reset release, CLR_ON_RST=1, ADDR_W=4:
//   - busy high for exactly 16 cycles.
//   - Afterwards, reads of addr 0..15 all return 0x0000 with rd_vld each.
// - Write addr=0x005, wrt_data=0xBEEF, be=2'b11, then read 0x005:
//   - RD_LAT=1: rd_data=0xBEEF with rd_vld one cycle after the read edge.
//   - RD_LAT=2: the same result arrives two cycles after the read edge.
// - After 0xBEEF is at 0x005, write 0x1234 with be=2'b01, then read:
//   - rd_data=0xBE34.
//   - A write with be=2'b00 leaves 0xBE34 unchanged.
// - re=1 and we=1 together at addr 0x005, wrt_data=0x0000:
//   - err pulses for 1 cycle; rd_vld stays 0; rd_data holds its prior value.
//   - A subsequent read still returns 0xBE34.
// - Requests driven while busy (write 0xFFFF to addr 3 at clear cycle 2):
//   - No err and no rd_vld.
//   - After clear completes, addr 3 reads 0x0000.
// - Pull rst_n low at clear cycle 7, release, count busy cycles:
//   - busy lasts the full 2**ADDR_W cycles again.
//   - Then 4 back-to-back reads of addrs 0,1,2,3 give 4 consecutive rd_vld pulses,
//     all data 0.

Source files
------------

// File: rtl/dm_param.sv
// Parametrised single-ported data memory with byte-lane writes, 1- or 2-cycle read
// latency and an optional post-reset zero-fill sequence that holds off requests via busy.
module dm_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                re,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wrt_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_vld,
  output logic                busy,
  output logic                err
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_acc, wr_acc, conflict;

  always_comb begin
    state_nxt = state;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    conflict  = 1'b0;
    case (state)
      CLEAR: if (&clr_addr) state_nxt = IDLE;
      IDLE: begin
        rd_acc   = re & ~we;
        wr_acc   = we & ~re;
        conflict = re & we;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLR_ON_RST != 0) state <= CLEAR;
      else                 state <= IDLE;
      clr_addr <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= conflict;
      // clr_addr rolls over to 0 exactly as the FSM leaves CLEAR
      if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
    end
  end

  assign busy = (state == CLEAR);

  // Array is never reset; the clear sequence is the only way to initialise it
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wrt_data[8*i +: 8];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] q_p0;
      logic              vld_p0;

      // Stage p0: array output register
      always_ff @(posedge clk) begin
        if (rd_acc) q_p0 <= mem[addr];
      end

      // Stage p1: output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p0  <= 1'b0;
          rd_vld  <= 1'b0;
          rd_data <= '0;
        end else begin
          vld_p0 <= rd_acc;
          rd_vld <= vld_p0;
          if (vld_p0) rd_data <= q_p0;
        end
      end
    end else begin : g_lat1
      // Stage p0: array read straight into the output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_vld  <= 1'b0;
          rd_data <= '0;
        end else begin
          rd_vld <= rd_acc;
          if (rd_acc) rd_data <= mem[addr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param: RD_LAT=1 and RD_LAT=2 instances on shared stimulus, checked
// cycle by cycle against a word-array model of the memory.
module tb_dm_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr = '0;
  logic        re = 1'b0, we = 1'b0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rd_data1, rd_data2;
  logic        rd_vld1, rd_vld2, busy1, busy2, err1, err2;

  dm_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .CLR_ON_RST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .be(be),
    .wrt_data(wdata), .rd_data(rd_data1), .rd_vld(rd_vld1), .busy(busy1), .err(err1));

  dm_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .CLR_ON_RST(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .be(be),
    .wrt_data(wdata), .rd_data(rd_data2), .rd_vld(rd_vld2), .busy(busy2), .err(err2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0] model [16];
  int          clr_left;
  logic [15:0] exp_d1, exp_d2, pend_d;
  logic        exp_v1, exp_v2, pend_v, exp_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a,
                       input logic [1:0] b, input logic [15:0] d);
    re = r; we = w; addr = a; be = b; wdata = d;
  endtask

  task automatic model_reset();
    exp_d1 = '0; exp_d2 = '0; exp_v1 = 1'b0; exp_v2 = 1'b0;
    pend_v = 1'b0; pend_d = '0; exp_err = 1'b0; clr_left = 0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    clr_left = 16;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".busy1"}, 16'(busy1), 16'(clr_left > 0));
    chk({tag, ".busy2"}, 16'(busy2), 16'(clr_left > 0));
    chk({tag, ".err1"}, 16'(err1), 16'(exp_err));
    chk({tag, ".err2"}, 16'(err2), 16'(exp_err));
    chk({tag, ".vld1"}, 16'(rd_vld1), 16'(exp_v1));
    chk({tag, ".vld2"}, 16'(rd_vld2), 16'(exp_v2));
    chk({tag, ".data1"}, rd_data1, exp_d1);
    chk({tag, ".data2"}, rd_data2, exp_d2);
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare
  task automatic cycle(input string tag);
    logic idle, rd, wr;
    @(posedge clk);
    idle = (clr_left == 0);
    if (!idle) clr_left--;
    rd = idle && re && !we;
    wr = idle && we && !re;
    exp_v2 = pend_v;
    if (pend_v) exp_d2 = pend_d;
    pend_v = rd;
    if (rd) pend_d = model[addr];
    exp_v1 = rd;
    if (rd) exp_d1 = model[addr];
    exp_err = idle && re && we;
    if (wr) begin
      if (be[0]) model[addr][7:0]  = wdata[7:0];
      if (be[1]) model[addr][15:8] = wdata[15:8];
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".rd_data1"}, rd_data1, 16'h0);
    chk({tag, ".rd_data2"}, rd_data2, 16'h0);
    chk({tag, ".rd_vld1"}, 16'(rd_vld1), 16'h0);
    chk({tag, ".rd_vld2"}, 16'(rd_vld2), 16'h0);
    chk({tag, ".err1"}, 16'(err1), 16'h0);
    chk({tag, ".busy1"}, 16'(busy1), 16'h1);
    chk({tag, ".busy2"}, 16'(busy2), 16'h1);
  endtask

  int bc, vc, op;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");

    // Release and count busy; random requests (and a write at cycle 2) must be ignored
    release_reset();
    bc = 0;
    for (int i = 0; i < 40 && busy1; i++) begin
      if (i == 1) drive(1'b0, 1'b1, 4'd3, 2'b11, 16'hFFFF);
      else drive(1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom), 16'($urandom));
      cycle("clear");
      bc++;
    end
    chk("busy_len", 16'(bc), 16'd16);

    // Every location reads zero after the clear
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b0, 4'(a), 2'b00, 16'h0);
      cycle("rd_zero");
    end
    drive(1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
    cycle("drain");
    cycle("drain");

    // Full write then latency check on both instances
    drive(1'b0, 1'b1, 4'h5, 2'b11, 16'hBEEF);
    cycle("wr_beef");
    drive(1'b1, 1'b0, 4'h5, 2'b00, 16'h0);
    cycle("rd_beef");
    chk("lat1_beef", rd_data1, 16'hBEEF);
    chk("lat1_vld", 16'(rd_vld1), 16'h1);
    chk("lat2_early_vld", 16'(rd_vld2), 16'h0);
    drive(1'b0, 1'b0, 4'h0, 2'b00, 16'h0);
    cycle("rd_beef2");
    chk("lat2_beef", rd_data2, 16'hBEEF);
    chk("lat2_vld", 16'(rd_vld2), 16'h1);

    // Low-lane partial write, then an all-lanes-disabled write
    drive(1'b0, 1'b1, 4'h5, 2'b01, 16'h1234);
    cycle("wr_lo");
    drive(1'b1, 1'b0, 4'h5, 2'b00, 16'h0);
    cycle("rd_be34");
    chk("partial_be34", rd_data1, 16'hBE34);
    drive(1'b0, 1'b1, 4'h5, 2'b00, 16'h0);
    cycle("wr_be0");
    drive(1'b1, 1'b0, 4'h5, 2'b00, 16'h0);
    cycle("rd_be0");
    chk("be0_noop", rd_data1, 16'hBE34);
    drive(1'b0, 1'b0, 4'h0, 2'b00, 16'h0);
    cycle("drain");

    // Simultaneous re/we: error pulse, no read, no write
    drive(1'b1, 1'b1, 4'h5, 2'b11, 16'h0000);
    cycle("conflict");
    chk("conflict_err", 16'(err1), 16'h1);
    chk("conflict_vld", 16'(rd_vld1), 16'h0);
    chk("conflict_hold", rd_data1, 16'hBE34);
    drive(1'b1, 1'b0, 4'h5, 2'b00, 16'h0);
    cycle("rd_after_conflict");
    chk("err_pulse_len", 16'(err1), 16'h0);
    chk("after_conflict", rd_data1, 16'hBE34);
    drive(1'b0, 1'b0, 4'h0, 2'b00, 16'h0);
    cycle("drain");

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      drive(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8,
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom));
      cycle("random");
    end
    drive(1'b0, 1'b0, 4'h0, 2'b00, 16'h0);
    cycle("drain");
    cycle("drain");

    // Reset again and abort the clear at cycle 7
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset2");
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    for (int i = 0; i < 7; i++) cycle("clear_part");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("abort");
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    bc = 0;
    for (int i = 0; i < 40 && busy1; i++) begin
      cycle("reclear");
      bc++;
    end
    chk("busy_len_restart", 16'(bc), 16'd16);

    // Back-to-back reads give a continuous valid train
    vc = 0;
    for (int a = 0; a < 5; a++) begin
      if (a < 4) drive(1'b1, 1'b0, 4'(a), 2'b00, 16'h0);
      else drive(1'b0, 1'b0, 4'h0, 2'b00, 16'h0);
      cycle("b2b");
      if (rd_vld1) vc++;
    end
    chk("b2b_vld_count", 16'(vc), 16'd4);
    cycle("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
